instr_fetch_master: RTL and testbench
=====================================

// Module: instr_fetch_master
// PURPOSE
//   Bus initiator that sequentially fetches 32-bit instruction words over the
//   req/gnt/rvalid bus and supplies them to the core through a valid/ready port.
//   Sits between the core front end and the instruction ROM/memory slave.
//   Pipelines up to MAX_OUTSTANDING reads, buffers responses in a DEPTH-entry
//   FIFO, supports redirect (branch) with discard of in-flight responses.
// PARAMETERS
//   DEPTH            4             response FIFO entries; power of 2, >=2
//   MAX_OUTSTANDING  3             max granted-but-unanswered reads, 1..DEPTH
//   BOOT_ADDR        32'h0000_0000 first fetch address after reset; word aligned
// PORTS
//   clk_i          in   1   clock
//   rst_ni         in   1   reset, asynchronous, active-low
//   fetch_en_i     in   1   1 = issue new requests; 0 = finish in-flight, issue none
//   branch_i       in   1   one-cycle redirect pulse
//   branch_addr_i  in   32  redirect target; bits[1:0] ignored (forced 0)
//   instr_valid_o  out  1   FIFO head valid
//   instr_ready_i  in   1   consumer accepts head when valid&&ready
//   instr_rdata_o  out  32  head instruction word
//   instr_addr_o   out  32  byte address of head word
//   instr_err_o    out  1   head word returned with bus error
//   bus_req_o      out  1   read request
//   bus_addr_o     out  32  request byte address, word aligned
//   bus_we_o       out  1   constant 0
//   bus_be_o       out  4   constant 4'hF
//   bus_gnt_i      in   1   request accepted this cycle
//   bus_rvalid_i   in   1   response valid (in order, >=1 cycle after gnt)
//   bus_rdata_i    in   32  response data
//   bus_err_i      in   1   response error, qualified by bus_rvalid_i
//   busy_o         out  1   outstanding!=0 or req pending
// BEHAVIOUR
//   Reset: req 0, bus_addr BOOT_ADDR, instr_valid 0, rdata/addr/err 0, busy 0,
//     FIFO empty, outstanding=0, discard=0, state FETCH.
//   States: FETCH (normal), HALT_ERR (error seen, no new requests).
//   bus_req_o derived from registers only (no comb path from bus inputs):
//     1 iff state==FETCH && fetch_en_i && outstanding<MAX_OUTSTANDING &&
//     fifo_count+outstanding<DEPTH, or a request is already pending.
//   Once raised, req and addr held stable until gnt; never withdrawn (also not
//     by branch, fetch_en_i drop or HALT_ERR).
//   gnt: outstanding++, req_addr+=4 (wraps mod 2^32).
//   rvalid: outstanding--; if discard>0: discard--, data dropped; else push
//     {resp_addr, rdata, err} to FIFO, resp_addr+=4. rvalid with outstanding==0
//     ignored.
//   Simultaneous gnt and rvalid in a cycle: outstanding unchanged.
//   Credit rule guarantees no FIFO overflow; simultaneous push/pop on full or
//     empty FIFO is legal; outputs are registered FIFO head.
//   Branch (cycle N): FIFO flushed (instr_valid 0 in N+1), rvalid in cycle N
//     dropped, discard = outstanding after cycle N updates, resp_addr and
//     req_addr = branch_addr; state->FETCH. If req pending ungranted at N, that
//     request completes at old address, is added to discard on its gnt, and
//     req_addr takes the target after that gnt.
//   Branch has priority over pop and push in the same cycle.
//   Error response pushed normally with err=1; state->HALT_ERR; only branch
//     exits HALT_ERR.
//   Latency (1-cycle-gnt slave, ready consumer): branch at N -> req with target
//     at N+1 -> rvalid N+2 -> instr_valid N+3. Steady throughput 1 word/cycle
//     with MAX_OUTSTANDING>=3.
//   Async reset mid-transfer: all state cleared immediately; stale rvalids
//     after reset ignored via outstanding==0 rule.
// TESTING
//   Reset, fetch_en=1, ROM gnt=req, rvalid 1 cycle later -> words at 0x0,0x4,
//     0x8,... one per cycle after 3-cycle start; instr_addr matches.
//   instr_ready=0 for 10 cycles -> req stops when fifo_count+outstanding==4,
//     no word lost; ready=1 resumes in order.
//   Branch to 0x100 with 2 outstanding -> both responses dropped, first output
//     addr 0x100.
//   Slave delays gnt 3 cycles, branch during wait -> addr held stable until gnt,
//     response discarded, next req addr = target.
//   bus_err_i on word at 0x8 -> emitted with err=1, no further req until branch
//     to 0x40 restarts fetch.
//   rst_ni asserted with 2 outstanding, then late rvalid -> ignored, outputs 0.

Source files
------------

// File: rtl/instr_fetch_master.sv
// Sequential instruction fetch initiator: pipelined word reads on a req/gnt/rvalid
// bus, responses buffered in a small FIFO and presented on a valid/ready port.
module instr_fetch_master #(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 3,
  parameter logic [31:0] BOOT_ADDR       = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        fetch_en_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_rdata_o,
  output logic [31:0] instr_addr_o,
  output logic        instr_err_o,
  output logic        bus_req_o,
  output logic [31:0] bus_addr_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_be_o,
  input  logic        bus_gnt_i,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_err_i,
  output logic        busy_o
);
  localparam int unsigned PW  = $clog2(DEPTH);
  localparam int unsigned CW  = $clog2(DEPTH + 1);
  localparam int unsigned CW1 = CW + 1;
  localparam logic [CW-1:0] MAX_OUT_C = CW'(MAX_OUTSTANDING);
  localparam logic [CW:0]   DEPTH_C   = CW1'(DEPTH);

  typedef enum logic [0:0] {FETCH = 1'b0, HALT_ERR = 1'b1} state_e;

  state_e        state_r, state_n_s;
  logic          req_r, req_n_s;
  logic [31:0]   req_addr_r, req_addr_n_s;
  logic          redir_r, redir_n_s;
  logic [31:0]   redir_addr_r, redir_addr_n_s;
  logic [31:0]   resp_addr_r, resp_addr_n_s;
  logic [CW-1:0] outs_r, outs_n_s;
  logic [CW-1:0] discard_r, disc_n_s;
  logic [CW-1:0] cnt_r, cnt_n_s;
  logic [CW:0]   credit_sum_s;
  logic [PW-1:0] wr_ptr_r, rd_ptr_r;
  logic [31:0]   fifo_addr_r [DEPTH];
  logic [31:0]   fifo_data_r [DEPTH];
  logic          fifo_err_r  [DEPTH];
  logic          gnt_s, rv_s, push_s, pop_s, dec_s, inc_s;
  logic [31:0]   tgt_s;

  // Next-state computation for counters, addresses, state and request.
  always_comb begin
    gnt_s  = req_r & bus_gnt_i;
    rv_s   = bus_rvalid_i & (outs_r != '0);
    tgt_s  = branch_addr_i & 32'hFFFF_FFFC;
    push_s = rv_s & ~branch_i & (discard_r == '0);
    pop_s  = (cnt_r != '0) & instr_ready_i & ~branch_i;
    dec_s  = rv_s & (discard_r != '0);
    inc_s  = gnt_s & redir_r;

    if (gnt_s && !rv_s) outs_n_s = outs_r + CW'(1);
    else if (!gnt_s && rv_s) outs_n_s = outs_r - CW'(1);
    else outs_n_s = outs_r;

    if (branch_i) cnt_n_s = '0;
    else if (push_s && !pop_s) cnt_n_s = cnt_r + CW'(1);
    else if (!push_s && pop_s) cnt_n_s = cnt_r - CW'(1);
    else cnt_n_s = cnt_r;

    // A redirected-but-ungranted request joins the discard count when it is granted.
    if (branch_i) disc_n_s = outs_n_s;
    else if (dec_s && !inc_s) disc_n_s = discard_r - CW'(1);
    else if (!dec_s && inc_s) disc_n_s = discard_r + CW'(1);
    else disc_n_s = discard_r;

    if (branch_i) state_n_s = FETCH;
    else if (push_s && bus_err_i) state_n_s = HALT_ERR;
    else state_n_s = state_r;

    req_addr_n_s   = req_addr_r;
    redir_n_s      = redir_r;
    redir_addr_n_s = redir_addr_r;
    if (branch_i && req_r && !bus_gnt_i) begin
      redir_n_s      = 1'b1;
      redir_addr_n_s = tgt_s;
    end else if (branch_i) begin
      req_addr_n_s = tgt_s;
      redir_n_s    = 1'b0;
    end else if (inc_s) begin
      req_addr_n_s = redir_addr_r;
      redir_n_s    = 1'b0;
    end else if (gnt_s) begin
      req_addr_n_s = req_addr_r + 32'd4;
    end else begin
      req_addr_n_s = req_addr_r;
    end

    if (branch_i) resp_addr_n_s = tgt_s;
    else if (push_s) resp_addr_n_s = resp_addr_r + 32'd4;
    else resp_addr_n_s = resp_addr_r;

    credit_sum_s = {1'b0, cnt_n_s} + {1'b0, outs_n_s};
    req_n_s = (req_r & ~bus_gnt_i) |
              ((state_n_s == FETCH) & fetch_en_i & (outs_n_s < MAX_OUT_C) &
               (credit_sum_s < DEPTH_C));
  end

  // Control registers and fetch state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r      <= FETCH;
      req_r        <= 1'b0;
      req_addr_r   <= BOOT_ADDR;
      redir_r      <= 1'b0;
      redir_addr_r <= 32'h0000_0000;
      resp_addr_r  <= BOOT_ADDR;
      outs_r       <= '0;
      discard_r    <= '0;
      cnt_r        <= '0;
    end else begin
      state_r      <= state_n_s;
      req_r        <= req_n_s;
      req_addr_r   <= req_addr_n_s;
      redir_r      <= redir_n_s;
      redir_addr_r <= redir_addr_n_s;
      resp_addr_r  <= resp_addr_n_s;
      outs_r       <= outs_n_s;
      discard_r    <= disc_n_s;
      cnt_r        <= cnt_n_s;
    end
  end

  // Response FIFO storage and pointers; a redirect empties it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fifo_addr_r[i] <= 32'h0000_0000;
        fifo_data_r[i] <= 32'h0000_0000;
        fifo_err_r[i]  <= 1'b0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else if (branch_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (push_s) begin
        fifo_addr_r[wr_ptr_r] <= resp_addr_r;
        fifo_data_r[wr_ptr_r] <= bus_rdata_i;
        fifo_err_r[wr_ptr_r]  <= bus_err_i;
        wr_ptr_r              <= wr_ptr_r + PW'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) rd_ptr_r <= rd_ptr_r + PW'(1);
      else rd_ptr_r <= rd_ptr_r;
    end
  end

  assign bus_req_o     = req_r;
  assign bus_addr_o    = req_addr_r;
  assign bus_we_o      = 1'b0;
  assign bus_be_o      = 4'hF;
  assign busy_o        = req_r | (outs_r != '0);
  assign instr_valid_o = (cnt_r != '0);
  assign instr_rdata_o = instr_valid_o ? fifo_data_r[rd_ptr_r] : 32'h0000_0000;
  assign instr_addr_o  = instr_valid_o ? fifo_addr_r[rd_ptr_r] : 32'h0000_0000;
  assign instr_err_o   = instr_valid_o ? fifo_err_r[rd_ptr_r] : 1'b0;

endmodule

// File: tb/tb_instr_fetch_master.sv
// Randomized bench for instr_fetch_master: behavioural bus slave plus an
// address-stream reference model of what the core should receive.
module tb_instr_fetch_master;
  localparam int MAXO = 3;

  logic        clk_i = 1'b0;
  logic        rst_ni, fetch_en_i, branch_i, instr_ready_i;
  logic [31:0] branch_addr_i, bus_rdata_i;
  logic        bus_gnt_i, bus_rvalid_i, bus_err_i;
  logic        instr_valid_o, instr_err_o, bus_req_o, bus_we_o, busy_o;
  logic [31:0] instr_rdata_o, instr_addr_o, bus_addr_o;
  logic [3:0]  bus_be_o;

  always #5 clk_i = ~clk_i;

  instr_fetch_master #(.DEPTH(4), .MAX_OUTSTANDING(3), .BOOT_ADDR(32'h0000_0000)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .fetch_en_i(fetch_en_i), .branch_i(branch_i),
    .branch_addr_i(branch_addr_i), .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
    .instr_rdata_o(instr_rdata_o), .instr_addr_o(instr_addr_o), .instr_err_o(instr_err_o),
    .bus_req_o(bus_req_o), .bus_addr_o(bus_addr_o), .bus_we_o(bus_we_o), .bus_be_o(bus_be_o),
    .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i),
    .bus_err_i(bus_err_i), .busy_o(busy_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Slave contents and error map
  logic        err_on = 1'b0;
  logic [31:0] err_addr = 32'h0;
  logic        rnd_err = 1'b0;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic errf(input logic [31:0] a);
    logic [7:0] w;
    w = a[9:2];
    return (err_on && a == err_addr) || (rnd_err && (w % 8'd41) == 8'd7);
  endfunction

  // Slave pending responses, knobs, sampled outputs, reference state
  logic [31:0] q_addr[$];
  int          q_due[$];
  int gnt_pct, lat_min, lat_max, rdy_pct, br_pct, fe_pct;
  logic        force_br = 1'b0;
  logic [31:0] force_tgt = 32'h0;
  logic        s_req, s_valid, s_err, s_busy;
  logic [31:0] s_addr, s_iaddr, s_rdata;
  int          cyc = 0;
  logic        prev_pend = 1'b0;
  logic [31:0] prev_addr = 32'h0;
  logic [31:0] exp_addr = 32'h0;
  int          n_words = 0;
  logic        saw_err = 1'b0;

  task automatic knobs(input int g, input int lmin, input int lmax, input int r, input int b, input int f);
    gnt_pct = g; lat_min = lmin; lat_max = lmax; rdy_pct = r; br_pct = b; fe_pct = f;
  endtask

  // One bus cycle: sample at negedge, drive inputs, update slave and reference model.
  task automatic step();
    int due;
    @(negedge clk_i);
    s_req = bus_req_o; s_addr = bus_addr_o; s_valid = instr_valid_o;
    s_iaddr = instr_addr_o; s_rdata = instr_rdata_o; s_err = instr_err_o; s_busy = busy_o;
    if (prev_pend) begin
      check_eq("req_held", 32'(s_req), 32'd1);
      check_eq("addr_held", s_addr, prev_addr);
    end
    bus_gnt_i = s_req && ($urandom_range(0, 99) < gnt_pct);
    if (q_addr.size() > 0 && q_due[0] <= cyc) begin
      bus_rvalid_i = 1'b1;
      bus_rdata_i  = rom(q_addr[0]);
      bus_err_i    = errf(q_addr[0]);
      void'(q_addr.pop_front());
      void'(q_due.pop_front());
    end else begin
      bus_rvalid_i = 1'b0;
      bus_rdata_i  = $urandom;
      bus_err_i    = 1'($urandom_range(0, 1));
    end
    instr_ready_i = ($urandom_range(0, 99) < rdy_pct);
    fetch_en_i    = ($urandom_range(0, 99) < fe_pct);
    if (force_br) begin
      branch_i = 1'b1; branch_addr_i = force_tgt; force_br = 1'b0;
    end else if ($urandom_range(0, 99) < br_pct) begin
      branch_i = 1'b1; branch_addr_i = $urandom & 32'h0000_0FFF;
    end else begin
      branch_i = 1'b0; branch_addr_i = $urandom;
    end
    if (branch_i) begin
      exp_addr = branch_addr_i & 32'hFFFF_FFFC;
    end else if (s_valid && instr_ready_i) begin
      check_eq("word_addr", s_iaddr, exp_addr);
      check_eq("word_data", s_rdata, rom(exp_addr));
      check_eq("word_err", 32'(s_err), 32'(errf(exp_addr)));
      if (s_err) saw_err = 1'b1;
      exp_addr = exp_addr + 32'd4;
      n_words++;
    end
    if (bus_gnt_i) begin
      due = cyc + $urandom_range(lat_min, lat_max);
      if (q_due.size() > 0 && q_due[$] > due) due = q_due[$];
      q_addr.push_back(s_addr);
      q_due.push_back(due);
      check_eq("outstanding_max", 32'(q_addr.size() <= MAXO), 32'd1);
    end
    prev_pend = s_req && !bus_gnt_i;
    prev_addr = s_addr;
    cyc++;
  endtask

  initial begin
    int vcnt, w0, k;
    logic [31:0] a_hold;
    logic v2;
    rst_ni = 1'b0; fetch_en_i = 1'b0; branch_i = 1'b0; branch_addr_i = 32'h0;
    instr_ready_i = 1'b0; bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0;
    bus_rdata_i = 32'h0; bus_err_i = 1'b0;
    repeat (2) @(negedge clk_i);
    check_eq("rst_req", 32'(bus_req_o), 32'd0);
    check_eq("rst_addr", bus_addr_o, 32'h0);
    check_eq("rst_valid", 32'(instr_valid_o), 32'd0);
    check_eq("rst_rdata", instr_rdata_o, 32'h0);
    check_eq("rst_iaddr", instr_addr_o, 32'h0);
    check_eq("rst_err", 32'(instr_err_o), 32'd0);
    check_eq("rst_busy", 32'(busy_o), 32'd0);
    check_eq("rst_we", 32'(bus_we_o), 32'd0);
    check_eq("rst_be", 32'(bus_be_o), 32'hF);
    rst_ni = 1'b1;

    // Streaming from boot: first word 3 cycles after fetch_en, then one per cycle
    knobs(100, 1, 1, 100, 0, 100);
    vcnt = 0; v2 = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (i == 2) v2 = s_valid;
      if (i >= 3 && s_valid) vcnt++;
    end
    check_eq("start_latency", 32'(v2), 32'd0);
    check_eq("throughput", 32'(vcnt), 32'd12);

    // Backpressure: requests stop when FIFO plus in-flight reach depth
    knobs(100, 1, 1, 0, 0, 100);
    repeat (10) step();
    check_eq("bp_req_stop", 32'(s_req), 32'd0);
    check_eq("bp_valid", 32'(s_valid), 32'd1);
    check_eq("bp_drained", 32'(q_addr.size()), 32'd0);
    w0 = n_words;
    knobs(100, 1, 1, 100, 0, 100);
    repeat (10) step();
    check_eq("bp_resume", 32'(n_words - w0 >= 8), 32'd1);

    // Branch with two reads outstanding
    knobs(100, 2, 2, 100, 0, 100);
    k = 0;
    while (k < 20 && q_addr.size() != 2) begin step(); k++; end
    check_eq("two_outstanding", 32'(q_addr.size()), 32'd2);
    force_br = 1'b1; force_tgt = 32'h0000_0100;
    step();
    k = 0;
    do begin step(); k++; end while (k < 20 && !s_valid);
    check_eq("br_first_addr", s_iaddr, 32'h0000_0100);

    // Branch while a request waits for grant
    knobs(0, 1, 1, 100, 0, 100);
    k = 0;
    do begin step(); k++; end while (k < 20 && !s_req);
    check_eq("wait_req_seen", 32'(s_req), 32'd1);
    a_hold = s_addr;
    force_br = 1'b1; force_tgt = 32'h0000_0203;
    step();
    step();
    check_eq("pend_addr_stable", s_addr, a_hold);
    gnt_pct = 100;
    step();
    step();
    check_eq("redir_req", 32'(s_req), 32'd1);
    check_eq("redir_addr", s_addr, 32'h0000_0200);
    k = 0;
    do begin step(); k++; end while (k < 20 && !s_valid);
    check_eq("redir_first_word", s_iaddr, 32'h0000_0200);

    // Bus error at 0x8 halts fetching until a branch
    err_on = 1'b1; err_addr = 32'h0000_0008; saw_err = 1'b0;
    knobs(100, 1, 1, 100, 0, 100);
    force_br = 1'b1; force_tgt = 32'h0000_0000;
    repeat (25) step();
    check_eq("err_seen", 32'(saw_err), 32'd1);
    check_eq("halt_req", 32'(s_req), 32'd0);
    check_eq("halt_busy", 32'(s_busy), 32'd0);
    check_eq("halt_valid", 32'(s_valid), 32'd0);
    force_br = 1'b1; force_tgt = 32'h0000_0040;
    step();
    step();
    check_eq("restart_req", 32'(s_req), 32'd1);
    check_eq("restart_addr", s_addr, 32'h0000_0040);
    w0 = n_words;
    repeat (10) step();
    check_eq("restart_flow", 32'(n_words - w0 >= 5), 32'd1);
    err_on = 1'b0;

    // Async reset with reads in flight; late responses must be ignored
    knobs(100, 3, 3, 0, 0, 100);
    k = 0;
    while (k < 20 && q_addr.size() < 2) begin step(); k++; end
    check_eq("rst_inflight", 32'(q_addr.size() >= 2), 32'd1);
    @(negedge clk_i);
    rst_ni = 1'b0; bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; fetch_en_i = 1'b0; branch_i = 1'b0;
    #1;
    check_eq("arst_req", 32'(bus_req_o), 32'd0);
    check_eq("arst_busy", 32'(busy_o), 32'd0);
    check_eq("arst_valid", 32'(instr_valid_o), 32'd0);
    repeat (2) @(negedge clk_i);
    cyc += 3;
    rst_ni = 1'b1;
    prev_pend = 1'b0; exp_addr = 32'h0;
    knobs(100, 1, 1, 100, 0, 0);
    repeat (6) step();
    check_eq("stale_drained", 32'(q_addr.size()), 32'd0);
    check_eq("stale_valid", 32'(s_valid), 32'd0);
    check_eq("stale_rdata", s_rdata, 32'h0);
    check_eq("stale_iaddr", s_iaddr, 32'h0);
    check_eq("stale_err", 32'(s_err), 32'd0);
    check_eq("stale_busy", 32'(s_busy), 32'd0);
    check_eq("stale_req", 32'(s_req), 32'd0);

    // Random traffic against the reference stream
    rnd_err = 1'b1;
    knobs(70, 1, 4, 70, 3, 90);
    w0 = n_words;
    repeat (3000) step();
    check_eq("random_progress", 32'(n_words - w0 >= 100), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
